// File: rtl/nvp_ctrl_regfile.sv
// rtl/nvp_ctrl_regfile.sv - AXI-Lite control/status register file for one NVP datapath core.
package NVP_v1_constants;
  parameter int CONTROL_AXI_DATA_WIDTH = 32;
  parameter int CONTROL_AXI_ADDR_WIDTH = 8;
endpackage

module nvp_ctrl_regfile #(
  parameter int          C_S_AXI_DATA_WIDTH = NVP_v1_constants::CONTROL_AXI_DATA_WIDTH,
  parameter int          C_S_AXI_ADDR_WIDTH = NVP_v1_constants::CONTROL_AXI_ADDR_WIDTH,
  parameter logic [31:0] VERSION            = 32'h0001_0000
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            start_o,
  output logic                            soft_rst_o,
  output logic [3:0][31:0]                cfg_o,
  input  logic                            busy_i,
  input  logic                            done_i,
  output logic                            irq_o
);

  if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_dw
    $error("nvp_ctrl_regfile: C_S_AXI_DATA_WIDTH must be 32");
  end
  if (C_S_AXI_ADDR_WIDTH < 5) begin : g_bad_aw
    $error("nvp_ctrl_regfile: C_S_AXI_ADDR_WIDTH must be >= 5");
  end

  logic              bvalid, rvalid;
  logic [1:0]        bresp, rresp;
  logic [31:0]       rdata, rd_val, scratch_q;
  logic [3:0][31:0]  cfg_q;
  logic              irq_en, done_q, err_q, start_q, soft_q, irq_q;
  logic              aw_bad, ar_bad, wr_hs, rd_hs, wr_ok, ctrl_wr, status_wr, start_req;
  logic [2:0]        wr_idx, rd_idx;
  logic              unused_addr_lsbs;

  // Address bits above the 8-word window flag the access as a slave error.
  if (C_S_AXI_ADDR_WIDTH > 5) begin : g_hi
    assign aw_bad = |S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:5];
    assign ar_bad = |S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:5];
  end else begin : g_no_hi
    assign aw_bad = 1'b0;
    assign ar_bad = 1'b0;
  end

  assign unused_addr_lsbs = &{1'b0, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign wr_idx    = S_AXI_AWADDR[4:2];
  assign rd_idx    = S_AXI_ARADDR[4:2];
  assign wr_hs     = S_AXI_ARESETN & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid;
  assign rd_hs     = S_AXI_ARESETN & S_AXI_ARVALID & ~rvalid;
  assign wr_ok     = wr_hs & ~aw_bad;
  assign ctrl_wr   = wr_ok & (wr_idx == 3'd0) & S_AXI_WSTRB[0];
  assign status_wr = wr_ok & (wr_idx == 3'd1) & S_AXI_WSTRB[0];
  assign start_req = ctrl_wr & S_AXI_WDATA[0];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] strb);
    merge = old;
    for (int b = 0; b < 4; b++)
      if (strb[b]) merge[8*b +: 8] = data[8*b +: 8];
  endfunction

  always_comb begin
    rd_val = '0;
    case (rd_idx)
      3'd0: rd_val = {29'd0, irq_en, 2'b00};
      3'd1: rd_val = {29'd0, err_q, done_q, busy_i};
      3'd2: rd_val = cfg_q[0];
      3'd3: rd_val = cfg_q[1];
      3'd4: rd_val = cfg_q[2];
      3'd5: rd_val = cfg_q[3];
      3'd6: rd_val = VERSION;
      3'd7: rd_val = scratch_q;
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      bvalid    <= 1'b0;
      bresp     <= 2'b00;
      rvalid    <= 1'b0;
      rresp     <= 2'b00;
      rdata     <= '0;
      cfg_q     <= '0;
      scratch_q <= '0;
      irq_en    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
      soft_q    <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      start_q <= start_req & ~busy_i;
      soft_q  <= ctrl_wr & S_AXI_WDATA[1];
      // Hardware set beats a same-cycle W1C so no event is lost.
      done_q  <= done_i | (done_q & ~(status_wr & S_AXI_WDATA[1]));
      err_q   <= (start_req & busy_i) | (err_q & ~(status_wr & S_AXI_WDATA[2]));
      irq_q   <= irq_en & (done_q | err_q);
      if (ctrl_wr) irq_en <= S_AXI_WDATA[2];
      for (int i = 0; i < 4; i++)
        if (wr_ok && wr_idx == 3'(i + 2))
          cfg_q[i] <= merge(cfg_q[i], S_AXI_WDATA, S_AXI_WSTRB);
      if (wr_ok && wr_idx == 3'd7)
        scratch_q <= merge(scratch_q, S_AXI_WDATA, S_AXI_WSTRB);

      if (wr_hs) begin
        bvalid <= 1'b1;
        bresp  <= aw_bad ? 2'b10 : 2'b00;
      end else if (S_AXI_BREADY) begin
        bvalid <= 1'b0;
      end

      if (rd_hs) begin
        rvalid <= 1'b1;
        rresp  <= ar_bad ? 2'b10 : 2'b00;
        rdata  <= ar_bad ? 32'd0 : rd_val;
      end else if (S_AXI_RREADY) begin
        rvalid <= 1'b0;
      end
    end
  end

  assign S_AXI_AWREADY = wr_hs;
  assign S_AXI_WREADY  = wr_hs;
  assign S_AXI_ARREADY = rd_hs;
  assign S_AXI_BVALID  = bvalid;
  assign S_AXI_BRESP   = bresp;
  assign S_AXI_RVALID  = rvalid;
  assign S_AXI_RRESP   = rresp;
  assign S_AXI_RDATA   = rdata;
  assign start_o       = start_q;
  assign soft_rst_o    = soft_q;
  assign cfg_o         = cfg_q;
  assign irq_o         = irq_q;

endmodule

// File: tb/tb_nvp_ctrl_regfile.sv
// tb/tb_nvp_ctrl_regfile.sv - randomized self-checking bench for nvp_ctrl_regfile.
module tb_nvp_ctrl_regfile;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic          awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 0;
  logic [31:0]   wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          awready, wready, bvalid, arready, rvalid;
  logic [1:0]    bresp, rresp;
  logic [31:0]   rdata;
  logic          start_o, soft_rst_o, irq_o;
  logic [3:0][31:0] cfg_o;
  logic          busy_i = 0, done_i = 0;

  always #5 clk = ~clk;

  nvp_ctrl_regfile dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .start_o(start_o), .soft_rst_o(soft_rst_o), .cfg_o(cfg_o),
    .busy_i(busy_i), .done_i(done_i), .irq_o(irq_o)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: register contents and event counts, kept as plain values.
  logic [31:0] m_cfg [4];
  logic [31:0] m_scratch;
  bit          m_irq_en, m_done, m_err;
  int          m_starts = 0, m_softs = 0, starts_seen = 0, softs_seen = 0;

  always @(negedge clk) begin
    if (start_o) starts_seen++;
    if (soft_rst_o) softs_seen++;
  end

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_cfg[i] = '0;
    m_scratch = '0;
    m_irq_en = 0; m_done = 0; m_err = 0;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old, input logic [31:0] d,
                                             input logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [AW-1:0] a, output logic [1:0] resp);
    int w = int'(a[4:2]);
    resp = 2'b00;
    if (a[AW-1:5] != 0) begin resp = 2'b10; return 32'd0; end
    if (w == 0) return {29'd0, m_irq_en, 2'b00};
    if (w == 1) return {29'd0, m_err, m_done, busy_i};
    if (w >= 2 && w <= 5) return m_cfg[w-2];
    if (w == 6) return 32'h0001_0000;
    return m_scratch;
  endfunction

  function automatic logic [1:0] model_write(input logic [AW-1:0] a, input logic [31:0] d,
                                             input logic [3:0] s, input bit busy, input bit done_same);
    int w = int'(a[4:2]);
    logic [1:0] resp = 2'b00;
    if (a[AW-1:5] != 0) resp = 2'b10;
    else if (w == 0 && s[0]) begin
      m_irq_en = d[2];
      if (d[0]) begin if (busy) m_err = 1; else m_starts++; end
      if (d[1]) m_softs++;
    end else if (w == 1 && s[0]) begin
      if (d[1]) m_done = 0;
      if (d[2]) m_err = 0;
    end else if (w >= 2 && w <= 5) m_cfg[w-2] = byte_merge(m_cfg[w-2], d, s);
    else if (w == 7) m_scratch = byte_merge(m_scratch, d, s);
    if (done_same) m_done = 1;
    return resp;
  endfunction

  task automatic check_outputs();
    for (int i = 0; i < 4; i++) check_eq($sformatf("cfg_o[%0d]", i), cfg_o[i], m_cfg[i]);
    check_eq("start_count", starts_seen, m_starts);
    check_eq("soft_rst_count", softs_seen, m_softs);
  endtask

  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit done_same);
    bit ok = 0;
    logic [1:0] eresp;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1; done_i = done_same;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (awready && wready) begin ok = 1; break; end
    end
    check_eq("wr_accept", 32'(ok), 32'd1);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; done_i = 0;
    eresp = model_write(a, d, s, busy_i, done_same);
    @(negedge clk);
    check_eq("bvalid", 32'(bvalid), 32'd1);
    check_eq("bresp", 32'(bresp), 32'(eresp));
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("bvalid_drop", 32'(bvalid), 32'd0);
    check_outputs();
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input int hold, output logic [31:0] d,
                          output logic [1:0] r);
    bit ok = 0;
    logic [31:0] exp;
    logic [1:0] eresp;
    @(posedge clk); #1;
    araddr = a; arvalid = 1; rready = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1; break; end
    end
    check_eq("rd_accept", 32'(ok), 32'd1);
    exp = model_read(a, eresp);
    @(posedge clk); #1;
    arvalid = 0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check_eq("rvalid_hold", 32'(rvalid), 32'd1);
      check_eq("rdata_hold", rdata, exp);
      @(posedge clk); #1;
    end
    rready = 1;
    @(negedge clk);
    check_eq("rvalid", 32'(rvalid), 32'd1);
    check_eq("rdata", rdata, exp);
    check_eq("rresp", 32'(rresp), 32'(eresp));
    d = rdata; r = rresp;
    @(posedge clk); #1;
    rready = 0;
  endtask

  task automatic pulse_done();
    @(posedge clk); #1; done_i = 1;
    @(posedge clk); #1; done_i = 0;
    m_done = 1;
  endtask

  task automatic check_irq();
    @(posedge clk);
    @(negedge clk);
    check_eq("irq_o", 32'(irq_o), 32'(m_irq_en & (m_done | m_err)));
  endtask

  logic [31:0] d;
  logic [1:0]  r;
  logic [1:0]  eresp;
  int          s0;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", {awready, wready, arready}, 0);
    check_eq("rst_valid", {bvalid, rvalid}, 0);
    check_eq("rst_resp_data", {bresp, rresp, rdata}, 0);
    check_eq("rst_pulses_irq", {start_o, soft_rst_o, irq_o}, 0);
    check_outputs();
    @(posedge clk); #1; rst_n = 1;

    // Config write, read-back and partial byte update.
    axi_write(8'h10, 32'hDEAD_BEEF, 4'hF, 0);
    check_eq("cfg2_full", cfg_o[2], 32'hDEAD_BEEF);
    axi_read(8'h10, 0, d, r);
    check_eq("cfg2_readback", d, 32'hDEAD_BEEF);
    axi_write(8'h10, 32'h0000_0011, 4'h1, 0);
    check_eq("cfg2_byte0", cfg_o[2], 32'hDEAD_BE11);

    // Start with irq enable, done -> irq, W1C -> irq clears.
    busy_i = 0; s0 = starts_seen;
    axi_write(8'h00, 32'h5, 4'hF, 0);
    check_eq("start_once", starts_seen - s0, 1);
    pulse_done();
    axi_read(8'h04, 0, d, r);
    check_eq("status_done", d, 32'h2);
    check_irq();
    check_eq("irq_set", 32'(irq_o), 32'd1);
    axi_write(8'h04, 32'h2, 4'hF, 0);
    check_irq();
    check_eq("irq_clear", 32'(irq_o), 32'd0);

    // Start while busy raises ERR instead.
    busy_i = 1; s0 = starts_seen;
    axi_write(8'h00, 32'h1, 4'hF, 0);
    check_eq("no_start_busy", starts_seen - s0, 0);
    axi_read(8'h04, 0, d, r);
    check_eq("status_busy_err", d, 32'h5);
    busy_i = 0;
    axi_write(8'h04, 32'h4, 4'hF, 0);

    // done_i coincident with DONE W1C: set wins.
    axi_write(8'h04, 32'h2, 4'hF, 1);
    axi_read(8'h04, 0, d, r);
    check_eq("done_set_wins", d, 32'h2);
    axi_write(8'h04, 32'h6, 4'hF, 0);

    // AW ahead of W, B back-pressure, second write stalled behind BVALID.
    @(posedge clk); #1;
    awaddr = 8'h1C; awvalid = 1; wvalid = 0; bready = 0;
    repeat (3) begin
      @(negedge clk); check_eq("aw_waits_w", 32'(awready), 32'd0);
      @(posedge clk); #1;
    end
    wdata = 32'hA5A5_0001; wstrb = 4'hF; wvalid = 1;
    @(negedge clk); check_eq("aw_with_w", 32'(awready & wready), 32'd1);
    @(posedge clk); #1;
    eresp = model_write(8'h1C, 32'hA5A5_0001, 4'hF, busy_i, 0);
    awaddr = 8'h14; wdata = 32'h1234_5678; wstrb = 4'h3;
    repeat (4) begin
      @(negedge clk);
      check_eq("bvalid_hold", 32'(bvalid), 32'd1);
      check_eq("second_stalled", 32'(awready | wready), 32'd0);
      @(posedge clk); #1;
    end
    bready = 1;
    @(posedge clk); #1;
    @(negedge clk); check_eq("second_accept", 32'(awready & wready), 32'd1);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    eresp = model_write(8'h14, 32'h1234_5678, 4'h3, busy_i, 0);
    @(negedge clk); check_eq("second_bvalid", 32'(bvalid), 32'd1);
    @(posedge clk); #1;
    check_outputs();
    axi_read(8'h1C, 0, d, r);

    // VERSION with RREADY back-pressure; out-of-range read and write.
    axi_read(8'h18, 2, d, r);
    check_eq("version", d, 32'h0001_0000);
    axi_read(8'h20, 0, d, r);
    check_eq("oor_rresp", 32'(r), 32'h2);
    check_eq("oor_rdata", d, 32'h0);
    axi_write(8'h3C, 32'hFFFF_FFFF, 4'hF, 0);

    // Randomized traffic against the model.
    for (int it = 0; it < 150; it++) begin
      int op = $urandom_range(0, 9);
      logic [AW-1:0] a = AW'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) a[AW-1:5] = 3'($urandom_range(1, 7));
      busy_i = ($urandom_range(0, 3) == 0);
      if (op <= 4) axi_write(a, $urandom, 4'($urandom), ($urandom_range(0, 5) == 0));
      else if (op <= 8) axi_read(a, $urandom_range(0, 2), d, r);
      else pulse_done();
      check_irq();
    end
    busy_i = 0;

    // Reset between the W handshake and BREADY.
    axi_write(8'h1C, 32'hCAFE_F00D, 4'hF, 0);
    @(posedge clk); #1;
    awaddr = 8'h08; wdata = 32'h0BAD_0BAD; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    @(negedge clk);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    @(negedge clk); check_eq("bvalid_pre_rst", 32'(bvalid), 32'd1);
    rst_n = 0; #1;
    check_eq("bvalid_async_drop", 32'(bvalid), 32'd0);
    model_reset();
    check_outputs();
    check_eq("irq_rst", 32'(irq_o), 32'd0);
    @(posedge clk); #1; rst_n = 1; bready = 1;
    repeat (3) begin
      @(negedge clk); check_eq("no_b_after_rst", 32'(bvalid), 32'd0);
    end
    axi_read(8'h1C, 0, d, r);
    check_eq("scratch_rst", d, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
